fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's address/enable pair; the memory returns the word one cycle later.
- Pairs each returned word with its PC and presents {pc, instr} to decode over a valid/ready handshake.
- Handles back-pressure and branch/jump redirects without losing or duplicating instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 1024, instruction memory size in bytes; power of two.
NOP, 32'h0000_0013, value of if_instr while if_valid is low (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
imem_addr  out  32  byte address to instruction memory; equals pc_q & (IMEM_BYTES-1); always word aligned.
imem_en  out  1  read enable to instruction memory; combinational from state, if_ready and redirect_valid.
imem_data  in  32  read data; valid in the cycle after imem_en was high.
if_valid  out  1  {if_pc, if_instr} valid to decode.
if_ready  in  1  decode accepts; transfer when if_valid & if_ready.
if_pc  out  32  full 32-bit PC of the presented instruction.
if_instr  out  32  presented instruction word.
redirect_valid  in  1  control-flow redirect request.
redirect_pc  in  32  redirect target; bits [1:0] are ignored (forced to 0).

Behaviour:
- Reset (async, any time, including mid-transfer):
  - pc_q=RESET_PC, inflight=0, FIFO emptied.
  - if_valid=0, if_pc=0, if_instr=NOP; imem_en=0 while rst_n low.
- State:
  - pc_q: next PC to request.
  - inflight flag and inflight_pc: request issued last cycle.
  - 2-entry FIFO of {pc, instr}; head drives if_pc/if_instr.
- pop = if_valid & if_ready.
- issue = ~redirect_valid & (count + inflight - pop < 2); imem_en = issue.
- On issue: pc_q <= pc_q+4, wrapping modulo 2^32; inflight <= 1; inflight_pc <= pc_q. Otherwise inflight <= 0.
- Response: if inflight is set and no redirect is present this cycle, push {inflight_pc, imem_data} at the cycle-end edge. Push and pop may occur in the same cycle.
- Latency: issue in cycle N -> if_valid in cycle N+2.
  - First issue occurs in the first cycle after rst_n rises.
  - With if_ready held high: one instruction per cycle, no bubbles.
- Back-pressure: if_ready low -> if_valid and its payload are held stable. The FIFO never overflows; the credit rule guarantees count+inflight<=2.
- Full: count=2 -> no issue until a pop. Empty: if_valid=0, if_instr=NOP.
- Redirect (priority over issue, push and pop):
  - Cycle R: imem_en=0; no FIFO pop or push. Any pop that decode sees in cycle R is discarded by decode.
  - Edge ending R: FIFO flushed, inflight cleared (the pending response is dropped), pc_q <= {redirect_pc[31:2], 2'b00}.
  - Cycle R+1: issue at the new PC; if_valid returns in R+3.
  - Back-to-back redirects: the last one wins.
- Address wrap: imem_addr masks pc_q to log2(IMEM_BYTES) bits. if_pc keeps the full pc_q.

Decomposition:
- Shared package riscv_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, DEFAULT_RESET_PC, fetch-entry struct {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: 2-entry synchronous FIFO with push, pop, flush, count[1:0], head data, and async active-low reset.
- The top level holds pc_q, the inflight tracking, issue/credit logic and redirect control.

Test Plan:
- Reset release, if_ready=1, memory word at byte k = k/4+1:
  - imem_addr 0,4,8,... one per cycle from cycle 0.
  - if_valid first in cycle 2 with if_pc=0, if_instr=1; then pc=4/instr=2, pc=8/instr=3 in consecutive cycles.
- Back-pressure, if_ready low cycles 3-6:
  - imem_en drops once count+inflight=2; if_pc=4 held stable.
  - After release: 4, 8, 12 in order; no gaps, no duplicates.
- Redirect, redirect_pc=32'h0000_0102 in cycle 5 with a request inflight and FIFO non-empty:
  - imem_en=0 in cycle 5; imem_addr=0x100 in cycle 6.
  - Next accepted instruction has if_pc=0x100; stale PCs never appear.
- Redirect on consecutive cycles to 0x40 then 0x80: only the 0x80 stream appears.
- Wrap: redirect to 0x3FC, IMEM_BYTES=1024 -> imem_addr 0x3FC then 0x000; if_pc 0x3FC then 0x400.
- Async reset asserted mid-stream with FIFO full:
  - if_valid falls without a clock edge; imem_en=0.
  - After release, the fetch restarts at RESET_PC with 2-cycle latency.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the front end: datapath width, the canonical NOP and
// the {pc, instr} entry that travels from fetch to decode.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry skid FIFO between the instruction memory and decode.
// Entry 0 is always the head; flush wins over push and pop.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0, e1;
    logic         do_pop, do_push;

    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);
    assign head    = e0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    // Count stays put; the new word lands behind whatever remains.
                    if (count == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues reads to a 1-cycle instruction memory
// and hands {pc, instr} to decode over valid/ready, with redirect support.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_BYTES = 1024,
    parameter logic [31:0] NOP        = INSTR_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1) & ~32'd3;

    logic [XLEN-1:0] pc_q, inflight_pc;
    logic            inflight;
    logic [1:0]      count;
    logic [2:0]      occ_after_pop;
    logic            pop, issue, push;
    fetch_entry_t    head, din;

    assign pop  = if_valid & if_ready;
    // Credit check: words held plus the one still in memory must fit after this pop.
    assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = ~redirect_valid & (occ_after_pop < 3'd2);
    assign push  = inflight & ~redirect_valid;

    assign imem_en   = issue & rst_n;
    assign imem_addr = pc_q & ADDR_MASK;

    assign din.pc    = inflight_pc;
    assign din.instr = imem_data;

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop & ~redirect_valid),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

    assign if_valid = (count != 2'd0);
    assign if_pc    = if_valid ? head.pc    : '0;
    assign if_instr = if_valid ? head.instr : NOP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            // The response for any outstanding read is dropped with the flush.
            pc_q     <= redirect_pc & ~32'd3;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc_q        <= pc_q + 32'd4;
                inflight_pc <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit with a scoreboard of the
// expected in-order instruction stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOPW   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_data = '0;
    logic        imem_en, if_valid, if_ready = 1'b0, redirect_valid = 1'b0;
    logic [31:0] if_pc, if_instr, redirect_pc = '0;

    fetch_unit #(.RESET_PC(RST_PC), .IMEM_BYTES(1024), .NOP(NOPW)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    exp_t        sbq[$];
    logic [31:0] gen_pc;
    int          n_checks = 0, n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a & 32'h3FF) >> 2) + 32'd1;
    endfunction

    // Instruction memory: word at byte k is k/4+1, one-cycle read latency.
    always @(posedge clk) if (imem_en) imem_data <= mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        exp_t e;
        while (sbq.size() < 16) begin
            e.pc = gen_pc; e.instr = mem_word(gen_pc);
            sbq.push_back(e);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    // Called just after a rising edge: sets this cycle's inputs and the expected stream.
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        if (rv) begin
            sbq.delete();
            gen_pc = rpc & ~32'd3;
        end
        topup();
    endtask

    // Monitor: in-order scoreboard, empty-state payload and back-pressure stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, if_valid}, 32'd1);
                chk("hold_pc", if_pc, prev_pc);
                chk("hold_instr", if_instr, prev_instr);
            end
            if (!if_valid) begin
                chk("empty_instr", if_instr, NOPW);
                chk("empty_pc", if_pc, 32'd0);
            end else if (if_ready && !redirect_valid) begin
                if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("sb_pc", if_pc, e.pc);
                    chk("sb_instr", if_instr, e.instr);
                end
            end
            prev_stall = if_valid & ~if_ready & ~redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
    end

    // Leaves the bench just after the edge that starts cycle 0 with rst_n high.
    task automatic do_reset();
        rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        sbq.delete(); gen_pc = RST_PC; topup();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, NOPW);
        chk("rst_en", {31'd0, imem_en}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // kind: 0 startup, 1 back-pressure, 2 redirect, 3 back-to-back redirect, 4 wrap
    task automatic directed(input int kind);
        logic        rdy, rv;
        logic [31:0] rpc;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            rdy = !(kind == 1 && c >= 3 && c <= 6);
            rv = 1'b0; rpc = '0;
            if (c == 5 && kind >= 2) begin
                rv = 1'b1;
                rpc = (kind == 2) ? 32'h102 : (kind == 3) ? 32'h40 : 32'h3FC;
            end
            if (kind == 3 && c == 6) begin rv = 1'b1; rpc = 32'h80; end
            drive(rdy, rv, rpc);
            @(negedge clk);
            case (kind)
                0: if (c < 5) begin
                    chk("start_en", {31'd0, imem_en}, 32'd1);
                    chk("start_addr", imem_addr, 32'(4 * c));
                    chk("start_valid", {31'd0, if_valid}, (c >= 2) ? 32'd1 : 32'd0);
                    if (c >= 2) begin
                        chk("start_pc", if_pc, 32'(4 * (c - 2)));
                        chk("start_instr", if_instr, 32'(c - 1));
                    end
                end
                1: begin
                    if (c == 3 || c == 4) chk("bp_en_low", {31'd0, imem_en}, 32'd0);
                    if (c >= 3 && c <= 6) begin
                        chk("bp_valid", {31'd0, if_valid}, 32'd1);
                        chk("bp_pc", if_pc, 32'd4);
                    end
                    if (c == 7) chk("bp_en_resume", {31'd0, imem_en}, 32'd1);
                    if (c == 9) chk("bp_pc_after", if_pc, 32'd12);
                end
                2: begin
                    if (c == 5) chk("rd_en_low", {31'd0, imem_en}, 32'd0);
                    if (c == 6) begin
                        chk("rd_en", {31'd0, imem_en}, 32'd1);
                        chk("rd_addr", imem_addr, 32'h100);
                    end
                    if (c == 6 || c == 7) chk("rd_bubble", {31'd0, if_valid}, 32'd0);
                    if (c == 8) chk("rd_pc", if_pc, 32'h100);
                end
                3: begin
                    if (c == 6) chk("b2b_en_low", {31'd0, imem_en}, 32'd0);
                    if (c == 7) chk("b2b_addr", imem_addr, 32'h80);
                    if (c == 9) chk("b2b_pc", if_pc, 32'h80);
                end
                default: begin
                    if (c == 6) chk("wrap_addr0", imem_addr, 32'h3FC);
                    if (c == 7) chk("wrap_addr1", imem_addr, 32'h000);
                    if (c == 8) begin
                        chk("wrap_pc0", if_pc, 32'h3FC);
                        chk("wrap_instr0", if_instr, 32'd256);
                    end
                    if (c == 9) begin
                        chk("wrap_pc1", if_pc, 32'h400);
                        chk("wrap_instr1", if_instr, 32'd1);
                    end
                end
            endcase
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) directed(k);

        // Fill the FIFO under back-pressure, then reset asynchronously mid-cycle.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, '0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("full_valid", {31'd0, if_valid}, 32'd1);
        chk("full_en", {31'd0, imem_en}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, if_valid}, 32'd0);
        chk("async_en", {31'd0, imem_en}, 32'd0);
        chk("async_instr", if_instr, NOPW);
        directed(0);

        // Random back-pressure and redirects against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
            @(posedge clk); #1;
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, '0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
